// File: rtl/aes_top_core.sv
// Iterative AES-128 encryptor: serial 32-bit load of plaintext and key, one round per clock,
// serial 32-bit ciphertext out. Optional macro AES_DOUT_ZERO_EN forces d_out to 0 while done=0.
module aes_top_core (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [31:0] d_in,
   output logic [31:0] d_out,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t       state, state_nxt;
   logic [127:0] blk, key;
   logic [127:0] key_nxt, rnd_out;
   logic [3:0]   cnt;
   logic         armed;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse as x^254 (Fermat); maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240, b;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      b    = gf_mul(gf_mul(x240, x12), x2);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // FIPS byte b sits at bits [127-8b -: 8]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
      logic [7:0]   b [16];
      logic [7:0]   h [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++) h[4*c+rr] = b[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
         a0 = h[4*c];
         a1 = h[4*c+1];
         a2 = h[4*c+2];
         a3 = h[4*c+3];
         if (last) r[127-32*c -: 32] = {a0, a1, a2, a3};
         else r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction

   always_comb begin
      key_nxt = key_expand(key, rcon(cnt));
      rnd_out = aes_round(blk, cnt == 4'd10) ^ key_nxt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!start && armed) state_nxt = LOAD;
         LOAD: if (cnt == 4'd5)     state_nxt = CALC;
         CALC: if (cnt == 4'd10)    state_nxt = OUT;
         OUT:  if (cnt == 4'd4)     state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // NOTE: these are plain registers, not RAM, so clearing them on reset is cheap and makes an abort clean.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         blk   <= '0;
         key   <= '0;
         cnt   <= '0;
         armed <= 1'b0;
         done  <= 1'b0;
         d_out <= '0;
      end else begin
         // NOTE: non-blocking everywhere here so every register samples pre-edge values.
         case (state)
            IDLE: begin
               cnt <= '0;
               if (start) begin
                  blk[31:0] <= d_in;
                  armed     <= 1'b1;
               end else if (armed) begin
                  blk[63:32] <= d_in;
                  armed      <= 1'b0;
               end
            end
            LOAD: begin
               case (cnt)
                  4'd0:    blk[95:64]  <= d_in;
                  4'd1:    blk[127:96] <= d_in;
                  4'd2:    key[31:0]   <= d_in;
                  4'd3:    key[63:32]  <= d_in;
                  4'd4:    key[95:64]  <= d_in;
                  default: key[127:96] <= d_in;
               endcase
               cnt <= (cnt == 4'd5) ? 4'd0 : cnt + 4'd1;
            end
            CALC: begin
               if (cnt == 4'd0) begin
                  blk <= blk ^ key;
               end else begin
                  blk <= rnd_out;
                  key <= key_nxt;
               end
               if (cnt == 4'd10) begin
                  d_out <= rnd_out[31:0];
                  done  <= 1'b1;
                  cnt   <= 4'd1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               case (cnt)
                  4'd1: d_out <= blk[63:32];
                  4'd2: d_out <= blk[95:64];
                  4'd3: d_out <= blk[127:96];
                  default: begin
                     done <= 1'b0;
`ifdef AES_DOUT_ZERO_EN
                     d_out <= '0;
`endif
                  end
               endcase
               cnt <= (cnt == 4'd4) ? 4'd0 : cnt + 4'd1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_top_core.sv
// Self-checking bench for aes_top_core: FIPS vectors, reset abort, back-to-back blocks
// and randomized blocks checked against a byte-level AES reference model.
module tb_aes_top_core;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic [31:0] d_in = '0;
   logic [31:0] d_out;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] sb [256];

   aes_top_core dut (
      .CLK  (CLK),
      .RST  (RST),
      .start(start),
      .d_in (d_in),
      .d_out(d_out),
      .done (done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
   endtask

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x] = s;
      end
   endtask

   function automatic logic [127:0] aes_model(input logic [127:0] p, input logic [127:0] k);
      logic [7:0]   st [16];
      logic [7:0]   t  [16];
      logic [7:0]   rk [176];
      logic [7:0]   tmp [4];
      logic [7:0]   rc, sv;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         st[i] = p[127-8*i -: 8];
         rk[i] = k[127-8*i -: 8];
      end
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = rk[4*(i-1)+j];
         if (i % 4 == 0) begin
            sv     = tmp[0];
            tmp[0] = sb[tmp[1]] ^ rc;
            tmp[1] = sb[tmp[2]];
            tmp[2] = sb[tmp[3]];
            tmp[3] = sb[sv];
            rc     = mul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) rk[4*i+j] = rk[4*(i-4)+j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[rr+4*c] = st[rr+4*((c+rr)%4)];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               if (r < 10)
                  st[rr+4*c] = mul(8'h02, t[rr+4*c]) ^ mul(8'h03, t[(rr+1)%4+4*c]) ^
                               t[(rr+2)%4+4*c] ^ t[(rr+3)%4+4*c];
               else
                  st[rr+4*c] = t[rr+4*c];
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r+i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // Drives the eight load words starting at a negedge; returns at the negedge right after edge T.
   task automatic load_block(input logic [127:0] p, input logic [127:0] k, input int nstart);
      for (int i = 0; i < nstart; i++) begin
         start = 1'b1;
         d_in  = p[31:0];
         @(negedge CLK);
      end
      start = 1'b0;
      for (int i = 1; i < 4; i++) begin
         d_in = p[32*i +: 32];
         @(negedge CLK);
      end
      for (int i = 0; i < 4; i++) begin
         d_in = k[32*i +: 32];
         @(negedge CLK);
      end
      d_in = $urandom;
   endtask

   // Full block: load, latency, four output words, then done falling. Returns at a negedge
   // in the cycle where done has just fallen, so the next block may start immediately.
   task automatic run_block(input string tag, input logic [127:0] p, input logic [127:0] k,
                            input logic [127:0] exp, input int nstart, input bit tog);
      int lat;
      load_block(p, k, nstart);
      lat = 0;
      while (!done && lat < 20) begin
         if (tog) start = 1'($urandom);
         @(negedge CLK);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd11);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            if (tog) start = 1'($urandom);
            @(negedge CLK);
         end
         check($sformatf("%s done w%0d", tag, i), 32'(done), 32'd1);
         check($sformatf("%s c%0d", tag, i), d_out, exp[32*i +: 32]);
      end
      start = 1'b0;
      @(negedge CLK);
      check({tag, " done fall"}, 32'(done), 32'd0);
`ifdef AES_DOUT_ZERO_EN
      check({tag, " dout after"}, d_out, 32'h0);
`else
      check({tag, " dout after"}, d_out, exp[127:96]);
`endif
   endtask

   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      logic [127:0] rp, rk;
      int           highs;
      build_sbox();
      repeat (3) @(negedge CLK);
      check("reset done", 32'(done), 32'd0);
      check("reset dout", d_out, 32'h0);
      RST = 1'b0;
      @(negedge CLK);

      run_block("c1", P_C1, K_C1, C_C1, 2, 1'b0);
      run_block("fips_b", P_B, K_B, C_B, 1, 1'b0);
      run_block("zero", '0, '0, C_Z, 3, 1'b0);

      // Abort in the middle of CALC.
      load_block(P_C1, K_C1, 2);
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      #1;
      check("abort done", 32'(done), 32'd0);
      check("abort dout", d_out, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (done || d_out != 0) highs++;
      end
      check("abort quiet", 32'(highs), 32'd0);
      run_block("c1 reload", P_C1, K_C1, C_C1, 2, 1'b0);

      // Back-to-back with start noise during CALC/OUT.
      run_block("b2b c1", P_C1, K_C1, C_C1, 2, 1'b1);
      run_block("b2b b", P_B, K_B, C_B, 1, 1'b1);

      for (int n = 0; n < 4; n++) begin
         rp = {$urandom, $urandom, $urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         run_block($sformatf("rand%0d", n), rp, rk, aes_model(rp, rk),
                   int'($urandom_range(1, 3)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
